// File: rtl/reaction_timer.sv
// Reaction timer: random 1-4.5 s wait, then measures milliseconds until the react button.
// Asynchronous divider clocks and buttons are synchronized and debounced in clk_12MHz.
module reaction_timer #(
  parameter int unsigned DEBOUNCE_MS = 10,
  parameter int unsigned MAX_MS      = 9999
) (
  input  logic        clk_12MHz,
  input  logic        rstn,
  input  logic        clk_1KHz,
  input  logic        clk_2Hz,
  input  logic        btn_start,
  input  logic        btn_react,
  output logic        led_go,
  output logic [13:0] result_ms,
  output logic        result_valid,
  output logic        foul,
  output logic        busy
);

  localparam int unsigned       DBW     = (DEBOUNCE_MS > 1) ? $clog2(DEBOUNCE_MS) : 1;
  localparam logic [DBW-1:0]    DB_LAST = DBW'(DEBOUNCE_MS - 1);
  localparam logic [13:0]       MAX_CNT = 14'(MAX_MS);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_GO, S_DONE, S_FOUL} state_t;

  // bit 0: clk_1KHz, 1: clk_2Hz, 2: btn_start, 3: btn_react
  logic [3:0]     r_meta;
  logic [3:0]     r_sync;
  logic [1:0]     r_clk_d;
  logic           r_tick_ms;
  logic           r_tick_2hz;
  logic [1:0]     r_db;
  logic [DBW-1:0] r_db_cnt [2];
  logic [1:0]     w_press;
  logic [7:0]     r_lfsr;
  state_t         r_state;
  logic [3:0]     r_delay;
  logic [13:0]    r_ms;

  always_ff @(posedge clk_12MHz or negedge rstn) begin
    if (!rstn) begin
      r_meta     <= '0;
      r_sync     <= '0;
      r_clk_d    <= '0;
      r_tick_ms  <= 1'b0;
      r_tick_2hz <= 1'b0;
    end else begin
      r_meta     <= {btn_react, btn_start, clk_2Hz, clk_1KHz};
      r_sync     <= r_meta;
      r_clk_d    <= r_sync[1:0];
      r_tick_ms  <= r_sync[0] & ~r_clk_d[0];
      r_tick_2hz <= r_sync[1] & ~r_clk_d[1];
    end
  end

  // Press fires on the same tick that completes the debounce, so it can coincide with tick_ms.
  always_comb begin
    w_press = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      w_press[i] = r_tick_ms & r_sync[2+i] & ~r_db[i] & (r_db_cnt[i] == DB_LAST);
    end
  end

  always_ff @(posedge clk_12MHz or negedge rstn) begin
    if (!rstn) begin
      r_db <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        r_db_cnt[i] <= '0;
      end
    end else if (r_tick_ms) begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (r_sync[2+i] == r_db[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_LAST) begin
          r_db[i]     <= r_sync[2+i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_12MHz or negedge rstn) begin
    if (!rstn) begin
      r_lfsr <= 8'h01;
    end else begin
      r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    end
  end

  always_ff @(posedge clk_12MHz or negedge rstn) begin
    if (!rstn) begin
      r_state      <= S_IDLE;
      r_delay      <= '0;
      r_ms         <= '0;
      led_go       <= 1'b0;
      result_ms    <= '0;
      result_valid <= 1'b0;
      foul         <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_FOUL: begin
          if (w_press[0]) begin
            r_state      <= S_WAIT;
            r_delay      <= 4'd2 + {1'b0, r_lfsr[2:0]};
            result_valid <= 1'b0;
            foul         <= 1'b0;
            busy         <= 1'b1;
          end
        end
        S_WAIT: begin
          if (w_press[1]) begin
            r_state <= S_FOUL;
            foul    <= 1'b1;
            busy    <= 1'b0;
          end else if (r_tick_2hz) begin
            if (r_delay <= 4'd1) begin
              r_state <= S_GO;
              r_delay <= '0;
              r_ms    <= '0;
              led_go  <= 1'b1;
            end else begin
              r_delay <= r_delay - 4'd1;
            end
          end
        end
        S_GO: begin
          if (w_press[1]) begin
            r_state      <= S_DONE;
            result_ms    <= r_ms;
            result_valid <= 1'b1;
            led_go       <= 1'b0;
            busy         <= 1'b0;
          end else if (r_tick_ms) begin
            if (r_ms == MAX_CNT) begin
              r_state      <= S_DONE;
              result_ms    <= MAX_CNT;
              result_valid <= 1'b1;
              led_go       <= 1'b0;
              busy         <= 1'b0;
            end else begin
              r_ms <= r_ms + 14'd1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          led_go  <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/reaction_timer.md
REACTION_TIMER -- requirements
Module: reaction_timer

Interface
REQ-001 Parameter: DEBOUNCE_MS, default 10, consecutive 1 ms ticks a button level SHALL be stable before acceptance.
REQ-002 Parameter: MAX_MS, default 9999, saturation/timeout value of the reaction count.
REQ-003 Port: clk_12MHz  in  1  system clock; the only clock of the block.
REQ-004 Port: rstn  in  1  reset, asynchronous, active-low.
REQ-005 Port: clk_1KHz  in  1  1 kHz square wave from the clock divider, treated as data (asynchronous).
REQ-006 Port: clk_2Hz  in  1  2 Hz square wave from the clock divider, treated as data (asynchronous).
REQ-007 Port: btn_start  in  1  raw start button, active-high, asynchronous, bouncy.
REQ-008 Port: btn_react  in  1  raw reaction button, active-high, asynchronous, bouncy.
REQ-009 Port: led_go  out  1  high while the subject must react.
REQ-010 Port: result_ms  out  14  last measured reaction time, milliseconds, binary.
REQ-011 Port: result_valid  out  1  result_ms holds a completed measurement.
REQ-012 Port: foul  out  1  last test aborted by an early react press.
REQ-013 Port: busy  out  1  high in WAIT or GO.

Function
REQ-014 clk_1KHz, clk_2Hz, btn_start, btn_react SHALL each pass a 2-flop synchronizer in clk_12MHz.
REQ-015 tick_ms / tick_2hz SHALL be single-cycle pulses on the synchronized rising edge of clk_1KHz / clk_2Hz, asserted 3 clk_12MHz cycles after the input rise is first sampled.
REQ-016 Per button: debounced level SHALL change only after the synchronized level differs from it on DEBOUNCE_MS consecutive tick_ms; any intermediate match SHALL restart the count.
REQ-017 Press event SHALL be a one-cycle pulse on debounced 0->1; release produces no event.
REQ-018 An 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1), seed 8'h01, SHALL advance every clk_12MHz cycle.
REQ-019 FSM states: IDLE, WAIT, GO, DONE, FOUL.
REQ-020 IDLE/DONE/FOUL + start press -> WAIT; load delay_cnt = 2 + lfsr[2:0] (2..9); clear result_valid and foul; result_ms unchanged.
REQ-021 WAIT: each tick_2hz decrements delay_cnt; the tick that takes it to 0 -> GO, ms_cnt = 0, led_go = 1 next cycle.
REQ-022 WAIT + react press -> FOUL, foul = 1, led_go stays 0; react press and final tick_2hz in the same cycle -> FOUL.
REQ-023 GO: each tick_ms increments ms_cnt, saturating at MAX_MS.
REQ-024 GO + react press -> DONE: result_ms = ms_cnt value before any same-cycle increment, result_valid = 1, led_go = 0.
REQ-025 GO with ms_cnt == MAX_MS on a tick_ms -> DONE: result_ms = MAX_MS, result_valid = 1, led_go = 0.
REQ-026 Start press in WAIT or GO SHALL be ignored; react press in IDLE/DONE/FOUL ignored; same-cycle start and react in IDLE/DONE/FOUL -> start wins.
REQ-027 Outputs SHALL be registered; led_go = (state == GO), busy = (state in WAIT, GO).

Reset
REQ-028 rstn low SHALL immediately force: state IDLE, led_go 0, result_ms 0, result_valid 0, foul 0, busy 0, LFSR 8'h01, all synchronizers, debounce counters, debounced levels, delay_cnt, ms_cnt to 0.
REQ-029 Reset asserted mid-WAIT or mid-GO SHALL discard the test; after release no press event SHALL be generated for a button already held until it is stable-high for DEBOUNCE_MS ticks.

Verification
REQ-030 Bounce: btn_react toggling every 2 ms for 20 ms in GO, then stable high -> exactly one press event, DEBOUNCE_MS=10 ticks after last bounce.
REQ-031 Normal: start press, LFSR[2:0]=3 at press -> GO after 5th tick_2hz; react press event after 237 tick_ms -> result_ms=237, result_valid=1, led_go=0, state DONE.
REQ-032 Foul: react press event during WAIT -> foul=1, state FOUL, led_go never 1, result_valid=0; new start press -> WAIT, foul=0.
REQ-033 Timeout: MAX_MS=50, no react in GO -> DONE on the 51st tick_ms with result_ms=50, result_valid=1.
REQ-034 Coincidence: react press and tick_ms same cycle at ms_cnt=99 -> result_ms=99; react and last tick_2hz same cycle in WAIT -> FOUL.
REQ-035 Reset: rstn pulsed low in GO with ms_cnt=400 -> all outputs 0, state IDLE on the same cycle; release -> no spurious events.
